mem_stage: RTL and testbench

MIPS pipeline memory-access stage, directly downstream of EXECUTE.
- Consumes the EXECUTE result (ALU output, store data, destination register, control bits).
- For loads and stores, performs a multi-cycle req/ack transaction to data RAM and stalls the upstream pipeline until it completes.
- Produces the registered MEM/WB bundle for writeback.

---
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS pipeline memory-access stage: issues req/ack RAM transactions for loads/stores and
// produces the registered MEM/WB bundle. Optional macro MEM_ALIGN_CHECK_EN traps misaligned accesses.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_aluout,
    input  logic [DATA_W-1:0] ex_regb,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wb_valid,
    output logic [DATA_W-1:0] mem_wb_data,
    output logic [REG_W-1:0]  mem_wb_rd,
    output logic              mem_wb_regwrite,
    output logic              align_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    state_t              state_next;
    logic                accept;
    logic                is_mem;
    logic                misaligned;
    logic [ADDR_W-1:0]   addr_next;

    logic [REG_W-1:0]    lat_rd;
    logic                lat_regwrite;
    logic                lat_memtoreg;
    logic [DATA_W-1:0]   lat_aluout;

    assign accept = ex_valid && (state == IDLE);
    assign is_mem = ex_memread || ex_memwrite;
    assign stall  = (state == BUSY);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_mem && (ex_aluout[1:0] != 2'b00);
    assign addr_next  = ADDR_W'(ex_aluout);
`else
    // Without the trap every access is silently forced onto a word boundary.
    assign misaligned = 1'b0;
    assign addr_next  = ADDR_W'(ex_aluout) & ~ADDR_W'(3);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_next = BUSY;
            BUSY: if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Retirement outputs pulse for one cycle; data/rd hold between retirements.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wb_valid    <= 1'b0;
            mem_wb_data     <= '0;
            mem_wb_rd       <= '0;
            mem_wb_regwrite <= 1'b0;
            align_err       <= 1'b0;
            lat_rd          <= '0;
            lat_regwrite    <= 1'b0;
            lat_memtoreg    <= 1'b0;
            lat_aluout      <= '0;
        end else begin
            mem_wb_valid    <= 1'b0;
            mem_wb_regwrite <= 1'b0;
            align_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem && !misaligned) begin
                            mem_req      <= 1'b1;
                            mem_we       <= ex_memwrite;
                            mem_addr     <= addr_next;
                            mem_wdata    <= ex_regb;
                            lat_rd       <= ex_rd;
                            lat_regwrite <= ex_regwrite;
                            lat_memtoreg <= ex_memtoreg;
                            lat_aluout   <= ex_aluout;
                        end else begin
                            mem_wb_valid    <= 1'b1;
                            mem_wb_data     <= ex_aluout;
                            mem_wb_rd       <= ex_rd;
                            mem_wb_regwrite <= ex_regwrite && !misaligned;
                            align_err       <= misaligned;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req         <= 1'b0;
                        mem_wb_valid    <= 1'b1;
                        mem_wb_data     <= lat_memtoreg ? mem_rdata : lat_aluout;
                        mem_wb_rd       <= lat_rd;
                        mem_wb_regwrite <= lat_regwrite;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: expected retirements are queued at issue and
// compared by a negedge monitor whenever the DUT pulses mem_wb_valid.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_aluout = '0;
    logic [31:0] ex_regb = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_regwrite = 1'b0;
    logic        ex_memread = 1'b0;
    logic        ex_memwrite = 1'b0;
    logic        ex_memtoreg = 1'b0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_wb_valid;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_regwrite;
    logic        align_err;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwrite;
        logic        align;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   retire_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   accept_cyc;

    mem_stage dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_aluout(ex_aluout),
        .ex_regb(ex_regb), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_wb_valid(mem_wb_valid), .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .align_err(align_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] alu, input logic [31:0] regb, input logic [4:0] rd,
                                  input logic rw, input logic mr, input logic mw, input logic m2r);
        ex_valid    = 1'b1;
        ex_aluout   = alu;
        ex_regb     = regb;
        ex_rd       = rd;
        ex_regwrite = rw;
        ex_memread  = mr;
        ex_memwrite = mw;
        ex_memtoreg = m2r;
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                                input logic al, input bit cd);
        exp_t e;
        e.data = d; e.rd = rd; e.regwrite = rw; e.align = al; e.chk_data = cd;
        return e;
    endfunction

    // Scoreboard monitor: every retirement must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_wb_valid) begin
                retire_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check_output("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk_data) check_output("wb_data", mem_wb_data, e.data);
                    check_output("wb_rd", {27'd0, mem_wb_rd}, {27'd0, e.rd});
                    check_output("wb_regwrite", {31'd0, mem_wb_regwrite}, {31'd0, e.regwrite});
                    check_output("align_err", {31'd0, align_err}, {31'd0, e.align});
                end
            end else begin
                check_output("idle_regwrite", {31'd0, mem_wb_regwrite}, 32'd0);
                check_output("idle_align_err", {31'd0, align_err}, 32'd0);
            end
        end
    end

    initial begin
        int n;
        $display("[TB] starting mem_stage test");
        tick();
        tick();
        check_output("rst_stall", {31'd0, stall}, 32'd0);
        check_output("rst_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_valid", {31'd0, mem_wb_valid}, 32'd0);
        check_output("rst_data", mem_wb_data, 32'd0);
        reset = 1'b0;
        tick();

        // ALU passthrough, three back-to-back
        apply_stimulus(32'd23, 32'd0, 5'd19, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(32'd23, 5'd19, 1'b1, 1'b0, 1'b1));
            tick();
            check_output("alu_stall", {31'd0, stall}, 32'd0);
        end
        ex_valid = 1'b0;
        tick();
        tick();
        n = retire_cyc.size();
        check_output("alu_retire_count", n, 32'd3);
        if (n >= 3) begin
            check_output("alu_consecutive_a", retire_cyc[n-2] - retire_cyc[n-3], 32'd1);
            check_output("alu_consecutive_b", retire_cyc[n-1] - retire_cyc[n-2], 32'd1);
        end

        // Load with ack after 3 BUSY cycles
        apply_stimulus(32'h40, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        sb.push_back(mk(32'hDEADBEEF, 5'd8, 1'b1, 1'b0, 1'b1));
        tick();
        accept_cyc = cyc;
        ex_valid = 1'b0;
        check_output("ld_req", {31'd0, mem_req}, 32'd1);
        check_output("ld_addr", mem_addr, 32'h40);
        check_output("ld_we", {31'd0, mem_we}, 32'd0);
        check_output("ld_stall1", {31'd0, stall}, 32'd1);
        tick();
        check_output("ld_stall2", {31'd0, stall}, 32'd1);
        tick();
        check_output("ld_stall3", {31'd0, stall}, 32'd1);
        check_output("ld_req_held", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        check_output("ld_done_stall", {31'd0, stall}, 32'd0);
        check_output("ld_done_req", {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        #1;
        check_output("ld_latency", retire_cyc[retire_cyc.size()-1] - accept_cyc, 32'd3);

        // Store, ack in first BUSY cycle
        tick();
        apply_stimulus(32'h44, 32'd13, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        sb.push_back(mk(32'h44, 5'd3, 1'b0, 1'b0, 1'b1));
        tick();
        accept_cyc = cyc;
        ex_valid = 1'b0;
        check_output("st_we", {31'd0, mem_we}, 32'd1);
        check_output("st_wdata", mem_wdata, 32'd13);
        check_output("st_stall", {31'd0, stall}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_output("st_done_req", {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        #1;
        check_output("st_latency", retire_cyc[retire_cyc.size()-1] - (accept_cyc - 1), 32'd2);

        // Load immediately followed by a held ALU op
        tick();
        apply_stimulus(32'h80, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        sb.push_back(mk(32'h12345678, 5'd4, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(32'd7, 5'd5, 1'b1, 1'b0, 1'b1));
        tick();
        apply_stimulus(32'd7, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_output("ldalu_stall", {31'd0, stall}, 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check_output("ldalu_unstall", {31'd0, stall}, 32'd0);
        tick();
        ex_valid = 1'b0;
        @(negedge clock);
        #1;
        n = retire_cyc.size();
        check_output("ldalu_gap", retire_cyc[n-1] - retire_cyc[n-2], 32'd1);

        // Misaligned load
        tick();
        apply_stimulus(32'h42, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
        sb.push_back(mk(32'h0, 5'd9, 1'b0, 1'b1, 1'b0));
        tick();
        ex_valid = 1'b0;
        check_output("mis_req", {31'd0, mem_req}, 32'd0);
        check_output("mis_stall", {31'd0, stall}, 32'd0);
        tick();
`else
        sb.push_back(mk(32'hCAFEF00D, 5'd9, 1'b1, 1'b0, 1'b1));
        tick();
        ex_valid = 1'b0;
        check_output("mis_req", {31'd0, mem_req}, 32'd1);
        check_output("mis_addr", mem_addr, 32'h40);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
`endif
        tick();

        // Reset mid-BUSY abandons the request; a late ack is ignored
        apply_stimulus(32'h100, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        check_output("rb_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        tick();
        tick();
        check_output("rb_stall", {31'd0, stall}, 32'd0);
        check_output("rb_req_cleared", {31'd0, mem_req}, 32'd0);
        check_output("rb_valid", {31'd0, mem_wb_valid}, 32'd0);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        check_output("late_ack_stall", {31'd0, stall}, 32'd0);
        check_output("late_ack_valid", {31'd0, mem_wb_valid}, 32'd0);
        check_output("late_ack_req", {31'd0, mem_req}, 32'd0);
        tick();
        tick();
        check_output("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
